// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: WIDTH-cycle shift-add multiply and
// restoring divide on operand magnitudes, with architectural HI/LO registers.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  // Control and architectural state
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Iteration datapath
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;

  // Request decode: op[2]=0 selects MULT/MULTU/DIV/DIVU, op[1] divide, op[0] unsigned
  logic             op_md, op_signed, op_div;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             accept_md;

  assign op_md     = ~op[2];
  assign op_signed = ~op[0];
  assign op_div    = op[1];
  assign sign_a    = op_signed & opA[WIDTH-1];
  assign sign_b    = op_signed & opB[WIDTH-1];
  assign mag_a     = sign_a ? (~opA + 1'b1) : opA;
  assign mag_b     = sign_b ? (~opB + 1'b1) : opB;
  assign accept_md = (state_q == S_IDLE) && start && op_md;

  // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_addend = acc_q[0] ? b_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: dividend bits leave the top of acc_q[WIDTH-1:0] as quotient bits enter the bottom
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] rem_diff;
  logic             q_bit;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  assign rem_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign rem_diff  = {1'b0, rem_shift} - {2'b00, b_q};
  assign q_bit     = ~rem_diff[WIDTH+1];
  assign rem_next  = q_bit ? rem_diff[WIDTH:0] : rem_shift;
  assign quo_next  = {acc_q[WIDTH-2:0], q_bit};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;

  assign product   = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quotient  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign remainder = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_md) begin
            state_d = S_RUN;
            count_d = '0;
          end else if (op == OP_MTHI) begin
            hi_d = opA;
          end else if (op == OP_MTLO) begin
            lo_d = opA;
          end
        end
      end
      S_RUN: begin
        if (count_q == LAST_ITER) begin
          state_d = S_FIX;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = product;
        end else if (dbz_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = remainder;
          lo_d = quotient;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    rem_d     = rem_q;
    b_d       = b_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;

    if (accept_md) begin
      acc_d     = {{WIDTH{1'b0}}, mag_a};
      rem_d     = '0;
      b_d       = mag_b;
      a_raw_d   = opA;
      is_div_d  = op_div;
      neg_res_d = sign_a ^ sign_b;
      neg_rem_d = sign_a;
      dbz_d     = op_div && (opB == '0);
    end else if (state_q == S_RUN) begin
      if (is_div_q) begin
        acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_next};
        rem_d = rem_next;
      end else begin
        acc_d = mul_next;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on acceptance before being read.
  always_ff @(posedge clock) begin
    acc_q     <= acc_d;
    rem_q     <= rem_d;
    b_q       <= b_d;
    a_raw_q   <= a_raw_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    dbz_q     <= dbz_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized
// ops compared against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .opA   (opA),
    .opB   (opB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural HI/LO result of an accepted op, by plain arithmetic
  task automatic model_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT: begin
        p = 64'(sa * sb);
        {m_hi, m_lo} = p;
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        {m_hi, m_lo} = p;
      end
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          if (o == OP_DIVU) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
          end
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Drive a request for one edge; called from a point away from the rising edge
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op    = o;
    opA   = a;
    opB   = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    opA   = $urandom;
    opB   = $urandom;
  endtask

  task automatic finish_md(input string tag, input int elapsed);
    int cyc     = elapsed;
    int busy_hi = 0;
    bit seen    = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) busy_hi++;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(W + 1));
    check({tag, " busy_run"}, 64'(busy_hi), 64'(cyc - elapsed - 1));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    model_op(o, a, b);
    start_op(o, a, b);
    check({tag, " busy_start"}, 64'(busy), 64'd1);
    check({tag, " done_start"}, 64'(done), 64'd0);
    finish_md(tag, 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    opA   = '0;
    opB   = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Signed and unsigned multiply corners
    run_md("mult_m1x2", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    check("mult_m1x2 hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("mult_m1x2 lo_const", 64'(lo), 64'hFFFF_FFFE);
    @(posedge clock);
    #1;
    check("done_one_cycle", 64'(done), 64'd0);
    run_md("multu_m1x2", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    check("multu_m1x2 hi_const", 64'(hi), 64'h0000_0001);
    run_md("mult_minxmin", OP_MULT, 32'h8000_0000, 32'h8000_0000);
    check("mult_minxmin hi_const", 64'(hi), 64'h4000_0000);

    // Divide: signed rounding, divide by zero, signed overflow
    run_md("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_m7_2 lo_const", 64'(lo), 64'hFFFF_FFFD);
    check("div_m7_2 hi_const", 64'(hi), 64'hFFFF_FFFF);
    run_md("divu_7_0", OP_DIVU, 32'h0000_0007, 32'h0000_0000);
    check("divu_7_0 lo_const", 64'(lo), 64'hFFFF_FFFF);
    check("divu_7_0 hi_const", 64'(hi), 64'h0000_0007);
    run_md("div_m7_0", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0000);
    run_md("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf lo_const", 64'(lo), 64'h8000_0000);
    check("div_ovf hi_const", 64'(hi), 64'h0000_0000);

    // MTHI in idle, then MTLO while busy must be ignored
    model_op(OP_MTHI, 32'h1234_5678, '0);
    start_op(OP_MTHI, 32'h1234_5678, '0);
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi done", 64'(done), 64'd0);
    model_op(OP_MULTU, 32'd3, 32'd5);
    start_op(OP_MULTU, 32'd3, 32'd5);
    repeat (8) begin
      @(posedge clock);
      #1;
    end
    start_op(OP_MTLO, 32'hDEAD_BEEF, '0);
    finish_md("multu_3x5_mtlo_busy", 9);
    check("multu_3x5 lo_const", 64'(lo), 64'd15);

    // Asynchronous reset mid-operation discards the op
    model_op(OP_DIVU, 32'd100, 32'd7);
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (14) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    check("async_rst busy", 64'(busy), 64'd0);
    check("async_rst done", 64'(done), 64'd0);
    check("async_rst hi", 64'(hi), 64'd0);
    check("async_rst lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    begin
      int done_cnt = 0;
      repeat (40) begin
        @(posedge clock);
        #1;
        if (done) done_cnt++;
      end
      check("async_rst no_done", 64'(done_cnt), 64'd0);
    end
    run_md("multu_6x7", OP_MULTU, 32'd6, 32'd7);

    // Back-to-back: second op issued in the done cycle of the first
    run_md("b2b_multu_2x3", OP_MULTU, 32'd2, 32'd3);
    run_md("b2b_divu_9_4", OP_DIVU, 32'd9, 32'd4);
    check("b2b_divu_9_4 lo_const", 64'(lo), 64'd2);
    check("b2b_divu_9_4 hi_const", 64'(hi), 64'd1);

    // Randomized mix of all op codes
    for (int i = 0; i < 30; i++) begin
      logic [2:0]   o;
      logic [W-1:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if (!o[2]) begin
        run_md($sformatf("rand%0d op%0d", i, o), o, a, b);
      end else begin
        model_op(o, a, b);
        start_op(o, a, b);
        check($sformatf("rand%0d op%0d hi", i, o), 64'(hi), 64'(m_hi));
        check($sformatf("rand%0d op%0d lo", i, o), 64'(lo), 64'(m_lo));
        check($sformatf("rand%0d op%0d busy", i, o), 64'(busy), 64'd0);
        check($sformatf("rand%0d op%0d done", i, o), 64'(done), 64'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It consumes the two register-file read ports (rs → opA, rt → opB). Its hi/lo outputs feed the write-back mux that drives the register file's writeData for MFHI/MFLO. Control holds the pipeline while busy is high.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clock  input  1  system clock, all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
start  input  1  op request, sampled on posedge clock.
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
opA  input  WIDTH  rs value (multiplicand/dividend/MTHI-MTLO data).
opB  input  WIDTH  rt value (multiplier/divisor).
busy  output  1  high while a MULT/DIV is in progress.
done  output  1  one-cycle pulse: hi/lo just updated by MULT/DIV.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. An in-flight op is discarded and hi/lo are not written.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter runs 0..WIDTH-1.
  - FIX: busy=1, one cycle.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU:
  - Latch operand magnitudes. Signed ops take |x| as a WIDTH-bit unsigned value; unsigned ops pass operands through.
  - Latch result signs and the op type. Go to RUN with counter=0.
- IDLE, start=1, op=MTHI/MTLO: hi (or lo) ← opA at this edge. No busy, no done.
- IDLE, start=1, op=11x: ignored.
- RUN: one iteration per clock, counter increments.
  - Multiply: shift-add, 2·WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, remainder WIDTH+1 bits.
  - After the iteration with counter=WIDTH-1, go to FIX.
- FIX:
  - Apply sign correction: product negated if signA^signB; quotient negated if signA^signB; remainder takes dividend sign.
  - Write hi/lo on this edge. Set done=1 for the following cycle and return to IDLE.
- Latency: start sampled at edge N. busy=1 from N through N+WIDTH+1; done=1 and new hi/lo visible after edge N+WIDTH+1, i.e. WIDTH+1 edges after the start edge (33 for WIDTH=32). busy=0 in the done cycle.
- Result mapping:
  - MULT/MULTU: hi=product[2W-1:W], lo=product[W-1:0].
  - DIV/DIVU: lo=quotient, hi=remainder.
- Divide by zero (DIV or DIVU, opB=0): lo=all ones, hi=opA unmodified. Same latency, done still pulses.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy=1 (any op, including MTHI/MTLO): ignored, no effect on state or hi/lo.
- start in the done cycle: accepted normally, since state is IDLE. Back-to-back ops therefore have no gap.
- opA/opB changes after the start edge: no effect, because operands are latched.
- hi/lo hold their value at all times except the FIX edge, the MTHI/MTLO edge, and reset.

Test Plan:
1. MULT opA=0xFFFFFFFF, opB=0x00000002 → after 33 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high for exactly 33 cycles.
2. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE. Then MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
3. DIV opA=0xFFFFFFF9 (−7), opB=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → lo=0xFFFFFFFF, hi=0x00000007. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. MTHI opA=0x12345678 in IDLE → hi=0x12345678 next cycle, busy/done stay 0. Then start MULTU 3×5 and, at cycle 10, MTLO 0xDEADBEEF → ignored; final hi=0, lo=15.
5. DIVU 100/7 started, reset pulsed at cycle 15 (async, mid-cycle) → busy=0, hi=lo=0 immediately, no done pulse. Next MULTU 6×7 → lo=42, hi=0.
6. Back-to-back: MULTU 2×3 followed by DIVU 9/4 issued in the done cycle → first done shows lo=6. Second done exactly 33 edges later shows lo=2, hi=1.
